// File: rtl/down_counter_timer_ctrl_pkg.sv
// Shared definitions for the down-counter timer controller: state encoding and default width.
package down_counter_timer_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/down_counter_timer_ctrl_core.sv
// Loadable WIDTH-bit down counter datapath; load beats enable and the count never wraps below zero.
module down_counter_core
    import down_counter_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             is_one
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en && (q_q != '0)) begin
            q_d = q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign is_one = (q_q == WIDTH'(1));

endmodule

// File: rtl/down_counter_timer_ctrl.sv
// Timer sequencing FSM: owns the down counter, the reload value and the sticky expiry irq.
module down_counter_timer_ctrl
    import down_counter_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             irq_q;
    logic             irq_d;
    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_en;
    logic             core_is_one;

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .q        (count),
        .is_one   (core_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            reload_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
        end
    end

    // Abort outranks everything, so it is tested before any per-state decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    state_d = (load_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (core_is_one) begin
                    state_d = DONE;
                end
            end
            PAUSED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (auto_reload && (reload_q != '0)) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_load     = 1'b0;
        core_load_val = '0;
        core_en       = 1'b0;
        reload_d      = reload_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    core_load     = 1'b1;
                    core_load_val = load_val;
                    reload_d      = load_val;
                end
            end
            RUN: begin
                if (abort) begin
                    core_load = 1'b1;
                end else if (!pause) begin
                    core_en = 1'b1;
                end
            end
            PAUSED: begin
                core_load = abort;
            end
            DONE: begin
                if (abort) begin
                    core_load = 1'b1;
                end else if (auto_reload && (reload_q != '0)) begin
                    core_load     = 1'b1;
                    core_load_val = reload_q;
                end
            end
            default: core_load = 1'b1;
        endcase
    end

    // irq rises together with done and cannot be cleared during the done cycle.
    always_comb begin
        irq_d = irq_q;
        if ((state_d == DONE) || (state_q == DONE)) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign irq  = irq_q;

endmodule

// File: tb/tb_down_counter_timer_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random traffic vs a model.
module tb_down_counter_timer_ctrl;

    localparam int W = 4;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         auto_reload = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         irq_clr = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         irq;

    int checks = 0;
    int errors = 0;

    int mPhase  = M_IDLE;
    int mCount  = 0;
    int mReload = 0;
    bit mIrq    = 1'b0;

    typedef struct {
        logic         rst;
        logic         start;
        logic [W-1:0] lv;
        logic         ar;
        logic         pause;
        logic         abort;
        logic         clr;
        int           eCount;
        logic         eBusy;
        logic         eDone;
        logic         eIrq;
    } vec_t;

    vec_t vecs[18];

    down_counter_timer_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .irq_clr     (irq_clr),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input int lv, input logic ar,
                                input logic p, input logic ab, input logic c,
                                input int ec, input logic eb, input logic ed, input logic ei);
        vec_t v;
        v.rst = r; v.start = s; v.lv = W'(lv); v.ar = ar; v.pause = p; v.abort = ab; v.clr = c;
        v.eCount = ec; v.eBusy = eb; v.eDone = ed; v.eIrq = ei;
        return v;
    endfunction

    // Timer behaviour stated as phases and an integer count, advanced once per clock.
    function automatic void modelStep(input logic r, input logic s, input int lv, input logic ar,
                                      input logic p, input logic ab, input logic c);
        int oldPhase = mPhase;
        if (r) begin
            mPhase = M_IDLE; mCount = 0; mReload = 0; mIrq = 1'b0;
            return;
        end
        if (oldPhase == M_IDLE) begin
            if (!ab && s) begin
                mReload = lv;
                mCount  = lv;
                mPhase  = (lv != 0) ? M_RUN : M_DONE;
            end
        end else if (ab) begin
            mPhase = M_IDLE;
            mCount = 0;
        end else if (oldPhase == M_RUN) begin
            if (p) begin
                mPhase = M_PAUSED;
            end else begin
                mCount = mCount - 1;
                if (mCount == 0) mPhase = M_DONE;
            end
        end else if (oldPhase == M_PAUSED) begin
            if (!p) mPhase = M_RUN;
        end else begin
            if (ar && mReload != 0) begin
                mCount = mReload;
                mPhase = M_RUN;
            end else begin
                mPhase = M_IDLE;
            end
        end
        if (mPhase == M_DONE || oldPhase == M_DONE) mIrq = 1'b1;
        else if (c) mIrq = 1'b0;
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic [W-1:0] lv, input logic ar,
                                 input logic p, input logic ab, input logic c);
        rst = r; start = s; load_val = lv; auto_reload = ar; pause = p; abort = ab; irq_clr = c;
        @(posedge clk);
        modelStep(r, s, int'(lv), ar, p, ab, c);
        #1;
    endtask

    task automatic expectOut(input string name, input int ec, input logic eb, input logic ed, input logic ei);
        checks++;
        if (count !== W'(ec) || busy !== eb || done !== ed || irq !== ei) begin
            errors++;
            $display("[TB] FAIL %s: got count=%0d busy=%b done=%b irq=%b, expected count=%0d busy=%b done=%b irq=%b",
                     name, count, busy, done, irq, ec, eb, ed, ei);
        end
    endtask

    task automatic checkOutput(input string name);
        expectOut(name, mCount, mPhase != M_IDLE, mPhase == M_DONE, mIrq);
    endtask

    initial begin
        int doneCount;

        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 7, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 5, 0, 0, 0, 0,  5, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0);
        vecs[5]  = mk(0, 1, 9, 0, 0, 0, 0,  3, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[14] = mk(0, 1, 2, 0, 0, 0, 0,  2, 1, 0, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].lv, vecs[i].ar,
                          vecs[i].pause, vecs[i].abort, vecs[i].clr);
            expectOut($sformatf("vec%0d", i), vecs[i].eCount, vecs[i].eBusy, vecs[i].eDone, vecs[i].eIrq);
        end

        // Pause for four cycles at count 3; decrement resumes one cycle after release.
        doneCount = 0;
        applyStimulus(0, 1, 5, 0, 0, 0, 0); expectOut("pause_start", 5, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("pause_c4", 4, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("pause_c3", 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            expectOut($sformatf("pause_hold%0d", i), 3, 1, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("pause_release", 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            if (done) doneCount++;
        end
        expectOut("pause_end", 0, 0, 0, 1);
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("[TB] FAIL pause_done_pulses: got %0d, expected 1", doneCount);
        end

        // Periodic mode with reload 3, then drop auto_reload and expect IDLE after the next expiry.
        applyStimulus(0, 1, 3, 1, 0, 0, 1); expectOut("per_start", 3, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            expectOut($sformatf("per_k%0d", k), (6 - (k % 4)) % 4, 1, (k % 4) == 2, k >= 2);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("per_off2", 2, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("per_off1", 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("per_off0", 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("per_idle", 0, 0, 0, 1);

        // Abort at count 2 with irq cleared: straight to IDLE, no done, irq stays 0.
        applyStimulus(0, 1, 5, 0, 0, 0, 1); expectOut("abort_start", 5, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("abort_c2", 2, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); expectOut("abort_idle", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); expectOut("abort_after", 0, 0, 0, 0);

        // Random traffic checked cycle by cycle against the model.
        applyStimulus(1, 0, 0, 0, 0, 0, 0); checkOutput("rand_reset");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          $urandom_range(0, 3) == 0,
                          W'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 7) == 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
